// File: rtl/bits_bank_search_pkg.sv
// Shared types and width helpers for the bits bank search/lock controller.
package bits_bank_search_pkg;

  // Controller states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_SCAN   = 3'd2,
    ST_DECIDE = 3'd3,
    ST_LOCKED = 3'd4
  } state_t;

  // Field positions inside corr_dat = {s4, s3, s2, s1}, each CORR_WIDTH bits.
  localparam int FIELD_S2 = 1;
  localparam int FIELD_S3 = 2;

  // Width of one correlator sum: it can reach LENGTH itself.
  function automatic int corr_width(input int length);
    return $clog2(length + 1);
  endfunction

  // Width of the bank select.
  function automatic int bank_width(input int banks);
    return (banks > 1) ? $clog2(banks) : 1;
  endfunction

  // Width of the saturating sample counter.
  function automatic int count_width(input int max_samples);
    return $clog2(max_samples + 1);
  endfunction

endpackage

// File: rtl/bits_bank_search_if.sv
// Control, correlator and status signals between the bank search block and its neighbours.
interface bits_bank_search_if #(
  parameter int LENGTH = 64,
  parameter int BANKS  = 16
);
  import bits_bank_search_pkg::*;

  localparam int CW = corr_width(LENGTH);
  localparam int BW = bank_width(BANKS);

  logic            i_start;
  logic            i_abort;
  logic [CW-1:0]   i_threshold;
  logic            i_in_vld;
  logic            i_corr_vld;
  logic [4*CW-1:0] i_corr_dat;
  logic [BW-1:0]   o_frequency_bank;
  logic            o_busy;
  logic            o_locked;
  logic [BW-1:0]   o_lock_bank;
  logic            o_lock_inv;
  logic [CW-1:0]   o_lock_score;
  logic            o_det_pulse;
  logic            o_timeout_pulse;
  logic            o_overrun;

  // Search controller side.
  modport slave (
    input  i_start, i_abort, i_threshold, i_in_vld, i_corr_vld, i_corr_dat,
    output o_frequency_bank, o_busy, o_locked, o_lock_bank, o_lock_inv,
           o_lock_score, o_det_pulse, o_timeout_pulse, o_overrun
  );

  // Driver side (correlator / control software model).
  modport master (
    output i_start, i_abort, i_threshold, i_in_vld, i_corr_vld, i_corr_dat,
    input  o_frequency_bank, o_busy, o_locked, o_lock_bank, o_lock_inv,
           o_lock_score, o_det_pulse, o_timeout_pulse, o_overrun
  );

endinterface

// File: rtl/bits_bank_search_score.sv
// Combinational bank score: the plain pattern sum s2, or the inverted sum s3 when it is
// strictly larger and inverted patterns are allowed.
module bits_bank_search_score
  import bits_bank_search_pkg::*;
#(
  parameter int CW        = 7,
  parameter int ALLOW_INV = 1
) (
  input  logic [4*CW-1:0] i_corr_dat,
  output logic [CW-1:0]   o_score,
  output logic            o_inv
);

  logic [CW-1:0] w_s2;
  logic [CW-1:0] w_s3;
  logic          w_s3_wins;

  assign w_s2      = i_corr_dat[FIELD_S2*CW +: CW];
  assign w_s3      = i_corr_dat[FIELD_S3*CW +: CW];
  // Equal sums favour the non-inverted pattern.
  assign w_s3_wins = (ALLOW_INV != 0) && (w_s3 > w_s2);
  assign o_score   = w_s3_wins ? w_s3 : w_s2;
  assign o_inv     = w_s3_wins;

endmodule

// File: rtl/bits_bank_search.sv
// Bank search/lock controller: sweeps the correlator bank select once per correlator
// output, keeps the best-scoring bank and locks it when the score reaches the threshold.
module bits_bank_search
  import bits_bank_search_pkg::*;
#(
  parameter int LENGTH      = 64,
  parameter int BANKS       = 16,
  parameter int ALLOW_INV   = 1,
  parameter int MAX_SAMPLES = 1024
) (
  input logic               clk,
  input logic               rst,
  bits_bank_search_if.slave bus
);

  localparam int CW = corr_width(LENGTH);
  localparam int BW = bank_width(BANKS);
  localparam int NW = count_width(MAX_SAMPLES);
  localparam logic [BW-1:0] LAST_BANK = BW'(BANKS - 1);
  localparam logic [NW-1:0] MAX_COUNT = NW'(MAX_SAMPLES);

  state_t        r_state;
  state_t        w_state_nxt;

  logic [BW-1:0] r_bank;
  logic [BW-1:0] w_bank_nxt;
  logic [CW-1:0] r_threshold;
  logic [NW-1:0] r_count;
  logic [NW-1:0] w_count_inc;
  logic [CW-1:0] r_best_score;
  logic [BW-1:0] r_best_bank;
  logic          r_best_inv;
  logic [BW-1:0] r_lock_bank;
  logic          r_lock_inv;
  logic [CW-1:0] r_lock_score;
  logic          r_det_pulse;
  logic          r_timeout_pulse;
  logic          r_overrun;

  logic [CW-1:0] w_score;
  logic          w_inv;
  logic          w_arm;
  logic          w_clr_best;
  logic          w_take_best;
  logic          w_overrun_set;
  logic          w_lock;
  logic          w_fail;
  logic          w_timeout;

  bits_bank_search_score #(
    .CW        (CW),
    .ALLOW_INV (ALLOW_INV)
  ) u_score (
    .i_corr_dat (bus.i_corr_dat),
    .o_score    (w_score),
    .o_inv      (w_inv)
  );

  // The counter saturates so it can never wrap back to a small value.
  assign w_count_inc = (r_count == MAX_COUNT) ? r_count : r_count + NW'(1);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and the one-cycle control strobes for the datapath.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
    w_state_nxt   = r_state;
    w_bank_nxt    = r_bank;
    w_arm         = 1'b0;
    w_clr_best    = 1'b0;
    w_take_best   = 1'b0;
    w_overrun_set = 1'b0;
    w_lock        = 1'b0;
    w_fail        = 1'b0;
    w_timeout     = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (bus.i_start) begin
          w_state_nxt = ST_WAIT;
          w_arm       = 1'b1;
          w_bank_nxt  = '0;
        end
      end
      ST_WAIT: begin
        w_clr_best = 1'b1;
        if (bus.i_corr_vld) begin
          w_state_nxt = ST_SCAN;
          w_bank_nxt  = '0;
        end
      end
      ST_SCAN: begin
        if (bus.i_in_vld) begin
          // The shift register moved mid-sweep: the partial best is meaningless.
          w_overrun_set = 1'b1;
          w_state_nxt   = ST_WAIT;
          w_bank_nxt    = '0;
        end else begin
          w_take_best = (w_score > r_best_score);
          if (r_bank == LAST_BANK) w_state_nxt = ST_DECIDE;
          else                     w_bank_nxt  = r_bank + BW'(1);
        end
      end
      ST_DECIDE: begin
        if (r_best_score >= r_threshold) begin
          w_lock      = 1'b1;
          w_state_nxt = ST_LOCKED;
          w_bank_nxt  = r_best_bank;
        end else begin
          w_fail     = 1'b1;
          w_bank_nxt = '0;
          if (w_count_inc == MAX_COUNT) begin
            w_timeout   = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end
      end
      ST_LOCKED: begin
        if (bus.i_start) begin
          w_state_nxt = ST_WAIT;
          w_arm       = 1'b1;
          w_bank_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_bank_nxt  = '0;
      end
    endcase

    // Abort overrides everything, including a lock or timeout decided this cycle.
    if (bus.i_abort) begin
      w_state_nxt   = ST_IDLE;
      w_bank_nxt    = '0;
      w_arm         = 1'b0;
      w_take_best   = 1'b0;
      w_overrun_set = 1'b0;
      w_lock        = 1'b0;
      w_fail        = 1'b0;
      w_timeout     = 1'b0;
    end
  end

  // Bank select, best candidate, sample counter, lock capture and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bank          <= '0;
      r_threshold     <= '0;
      r_count         <= '0;
      r_best_score    <= '0;
      r_best_bank     <= '0;
      r_best_inv      <= 1'b0;
      r_lock_bank     <= '0;
      r_lock_inv      <= 1'b0;
      r_lock_score    <= '0;
      r_det_pulse     <= 1'b0;
      r_timeout_pulse <= 1'b0;
      r_overrun       <= 1'b0;
    end else begin
      r_bank          <= w_bank_nxt;
      r_det_pulse     <= w_lock;
      r_timeout_pulse <= w_timeout;

      if (w_arm) begin
        r_threshold <= bus.i_threshold;
        r_count     <= '0;
      end else if (w_fail) begin
        r_count <= w_count_inc;
      end

      if (w_arm)              r_overrun <= 1'b0;
      else if (w_overrun_set) r_overrun <= 1'b1;

      if (w_clr_best) begin
        r_best_score <= '0;
        r_best_bank  <= '0;
        r_best_inv   <= 1'b0;
      end else if (w_take_best) begin
        r_best_score <= w_score;
        r_best_bank  <= r_bank;
        r_best_inv   <= w_inv;
      end

      if (w_lock) begin
        r_lock_bank  <= r_best_bank;
        r_lock_inv   <= r_best_inv;
        r_lock_score <= r_best_score;
      end
    end
  end

  assign bus.o_frequency_bank = r_bank;
  assign bus.o_busy           = (r_state == ST_WAIT) || (r_state == ST_SCAN) ||
                                (r_state == ST_DECIDE);
  assign bus.o_locked         = (r_state == ST_LOCKED);
  assign bus.o_lock_bank      = r_lock_bank;
  assign bus.o_lock_inv       = r_lock_inv;
  assign bus.o_lock_score     = r_lock_score;
  assign bus.o_det_pulse      = r_det_pulse;
  assign bus.o_timeout_pulse  = r_timeout_pulse;
  assign bus.o_overrun        = r_overrun;

endmodule
